// File: rtl/fp6_pkg.sv
// Shared FP6 (E2M3) definitions: field layout, zero constant, accumulator states
// and a magnitude decode helper used by the adder.
package fp6_pkg;

    localparam int FP6_EXP_W = 2;
    localparam int FP6_MAN_W = 3;
    localparam int FP6_W     = 1 + FP6_EXP_W + FP6_MAN_W;

    typedef struct packed {
        logic                 sign;
        logic [FP6_EXP_W-1:0] exp;
        logic [FP6_MAN_W-1:0] man;
    } fp6_t;

    localparam fp6_t FP6_ZERO = 6'b000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

    // Unsigned magnitude in units of 1/8 (exponent bias 1, exp=0 is subnormal).
    function automatic logic [5:0] fp6_magnitude(input fp6_t x);
        logic [5:0] mag;
        case (x.exp)
            2'd0:    mag = {3'b000, x.man};
            2'd1:    mag = {2'b00, 1'b1, x.man};
            2'd2:    mag = {1'b0, 1'b1, x.man, 1'b0};
            default: mag = {1'b1, x.man, 2'b00};
        endcase
        return mag;
    endfunction

    function automatic logic fp6_is_zero(input fp6_t x);
        return (x.exp == '0) && (x.man == '0);
    endfunction

endpackage

// File: rtl/fp6_adder.sv
// Combinational FP6 E2M3 adder: exact integer sum in 1/8 units, round-to-nearest-even,
// saturation to +/-7.5, pass-through when either operand is zero, exact cancel gives +0.
module fp6_adder
    import fp6_pkg::*;
(
    input  logic [FP6_W-1:0] a,
    input  logic [FP6_W-1:0] b,
    output logic [FP6_W-1:0] sum
);

    fp6_t       a_f;
    fp6_t       b_f;
    fp6_t       res;
    logic [5:0] mag_a;
    logic [5:0] mag_b;
    logic [7:0] sa;
    logic [7:0] sb;
    logic [7:0] ssum;
    logic [7:0] mag;
    logic [4:0] q_rnd;

    assign a_f = a;
    assign b_f = b;
    assign sum = res;

    // NOTE: every variable assigned in this block gets a default first so no latch is inferred.
    always_comb begin
        mag_a = fp6_magnitude(a_f);
        mag_b = fp6_magnitude(b_f);
        sa    = a_f.sign ? (8'd0 - {2'b00, mag_a}) : {2'b00, mag_a};
        sb    = b_f.sign ? (8'd0 - {2'b00, mag_b}) : {2'b00, mag_b};
        ssum  = sa + sb;
        mag   = ssum[7] ? (8'd0 - ssum) : ssum;
        q_rnd = '0;
        res   = FP6_ZERO;

        if (fp6_is_zero(a_f)) begin
            res = b_f;
        end else if (fp6_is_zero(b_f)) begin
            res = a_f;
        end else if (mag == 8'd0) begin
            res = FP6_ZERO;
        end else begin
            res.sign = ssum[7];
            if (mag < 8'd16) begin
                // Subnormal and exp=1 ranges are spaced 1/8 apart, so the sum is exact.
                res.exp = {1'b0, mag[3]};
                res.man = mag[2:0];
            end else if (mag < 8'd32) begin
                // One discarded bit: it is always the exact half, so round to even.
                q_rnd   = {1'b0, mag[4:1]} + {4'd0, mag[0] & mag[1]};
                res.exp = q_rnd[4] ? 2'd3 : 2'd2;
                res.man = q_rnd[2:0];
            end else if (mag < 8'd64) begin
                q_rnd   = {1'b0, mag[5:2]} + {4'd0, mag[1] & (mag[0] | mag[2])};
                res.exp = 2'd3;
                res.man = q_rnd[4] ? 3'd7 : q_rnd[2:0];
            end else begin
                res.exp = 2'd3;
                res.man = 3'd7;
            end
        end
    end

endmodule

// File: rtl/fp6_group_accumulator.sv
// Folds a valid/ready stream of FP6 partial products into one registered sum per
// group; a group closes on in_last or after VEC_LEN elements.
module fp6_group_accumulator
    import fp6_pkg::*;
#(
    parameter int VEC_LEN = 16,
    parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_data,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ACCUM = ACCUM;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]       state;
    fp6_t             acc;
    logic [5:0]       sum;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             closing;

    fp6_adder u_adder (
        .a   (acc),
        .b   (in_data),
        .sum (sum)
    );

    // in_ready is gated by rst_n so nothing is taken while reset is held.
    assign in_ready  = rst_n && (state != ST_DONE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign closing   = accept && (in_last || (count == CNT_W'(VEC_LEN - 1)));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc       <= FP6_ZERO;
            count     <= '0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_ACCUM: begin
                    if (accept) begin
                        acc   <= sum;
                        count <= count + 1'b1;
                        if (closing) begin
                            state     <= ST_DONE;
                            out_data  <= sum;
                            out_count <= count + 1'b1;
                        end else begin
                            state <= ST_ACCUM;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                        acc   <= FP6_ZERO;
                        count <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp6_group_accumulator.sv
// Self-checking bench: directed group scenarios plus a random stream checked against
// a value-level FP6 reference (real-number grid search with round-half-even).
module tb_fp6_group_accumulator;

    localparam int VEC_LEN = 4;
    localparam int CNT_W   = $clog2(VEC_LEN + 1);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       out_data;
    logic [CNT_W-1:0] out_count;

    fp6_group_accumulator #(.VEC_LEN(VEC_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Signed value of an FP6 code in units of 1/8.
    function automatic int fp6_value(input logic [5:0] x);
        int e;
        int m;
        int mag;
        e   = int'(x[4:3]);
        m   = int'(x[2:0]);
        mag = (e == 0) ? m : ((8 + m) << (e - 1));
        return x[5] ? -mag : mag;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference add: pick the nearest representable magnitude, ties to even mantissa.
    function automatic logic [5:0] ref_add(input logic [5:0] a, input logic [5:0] b);
        int         s;
        int         best;
        int         best_d;
        int         d;
        logic [5:0] code;
        if (a[4:0] == 5'd0) return b;
        if (b[4:0] == 5'd0) return a;
        s = fp6_value(a) + fp6_value(b);
        if (s == 0) return 6'h00;
        best   = 0;
        best_d = 1 << 20;
        for (int c = 0; c < 32; c++) begin
            code = 6'(c);
            d    = iabs(fp6_value(code) - iabs(s));
            if (d < best_d || (d == best_d && code[0] == 1'b0)) begin
                best   = c;
                best_d = d;
            end
        end
        code = 6'(best);
        return {(s < 0), code[4:0]};
    endfunction

    // Transaction-level model state.
    logic [5:0] grp[$];
    logic       m_done = 1'b0;
    logic [5:0] exp_data = '0;
    int         exp_count = 0;
    int         n_acc = 0;
    int         n_closed = 0;
    int         n_out = 0;
    int         out_sum = 0;

    // One cycle: drive inputs at the falling edge, check outputs, update the model.
    task automatic step(input logic v, input logic [5:0] d, input logic l, input logic ordy,
                        output logic accepted);
        logic [5:0] fold;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = ordy;
        #1;
        check("in_ready", in_ready, !m_done);
        check("out_valid", out_valid, m_done);
        if (m_done) begin
            check("out_data", out_data, exp_data);
            check("out_count", out_count, exp_count);
        end
        accepted = v && !m_done;
        if (m_done) begin
            if (ordy) begin
                m_done = 1'b0;
                n_out++;
                out_sum += int'(out_count);
            end
        end else if (accepted) begin
            n_acc++;
            grp.push_back(d);
            if (l || grp.size() == VEC_LEN) begin
                fold = 6'h00;
                foreach (grp[i]) fold = ref_add(fold, grp[i]);
                exp_data  = fold;
                exp_count = grp.size();
                grp.delete();
                m_done = 1'b1;
                n_closed++;
            end
        end
        @(negedge clk);
    endtask

    logic       acc_flag;
    logic       pv;
    logic [5:0] pd;
    logic       pl;
    int         bubbles;
    int         idx;
    int         cyc;
    logic [5:0] b2b_data [6];

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_count", out_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Length-closed group, no in_last.
        step(1'b1, 6'h08, 1'b0, 1'b1, acc_flag);
        step(1'b1, 6'h08, 1'b0, 1'b1, acc_flag);
        step(1'b1, 6'h00, 1'b0, 1'b1, acc_flag);
        step(1'b1, 6'h00, 1'b0, 1'b1, acc_flag);
        #1;
        check("len_close_sum", out_data, 6'h10);
        check("len_close_count", out_count, 4);
        step(1'b0, 6'h00, 1'b0, 1'b1, acc_flag);

        // Single-element group from IDLE.
        step(1'b1, 6'h2B, 1'b1, 1'b1, acc_flag);
        #1;
        check("single_sum", out_data, 6'h2B);
        check("single_count", out_count, 1);
        step(1'b0, 6'h00, 1'b0, 1'b1, acc_flag);

        // Result held under backpressure while a new element waits upstream.
        step(1'b1, 6'h08, 1'b0, 1'b0, acc_flag);
        step(1'b1, 6'h28, 1'b0, 1'b0, acc_flag);
        step(1'b1, 6'h00, 1'b1, 1'b0, acc_flag);
        for (int i = 0; i < 5; i++) step(1'b1, 6'h3F, 1'b1, 1'b0, acc_flag);
        step(1'b1, 6'h3F, 1'b1, 1'b1, acc_flag);
        step(1'b1, 6'h3F, 1'b1, 1'b1, acc_flag);
        check("held_elem_taken", acc_flag, 1);
        step(1'b0, 6'h00, 1'b0, 1'b1, acc_flag);

        // Back-to-back groups with in_valid held high.
        b2b_data = '{6'h08, 6'h08, 6'h18, 6'h20, 6'h30, 6'h2B};
        idx      = 0;
        bubbles  = 0;
        for (int c = 0; c < 20 && idx < 6; c++) begin
            if (!in_ready) bubbles++;
            step(1'b1, b2b_data[idx], idx[0], 1'b1, acc_flag);
            if (acc_flag) idx++;
        end
        check("b2b_all_taken", idx, 6);
        check("b2b_bubbles", bubbles, 2);
        step(1'b0, 6'h00, 1'b0, 1'b1, acc_flag);

        // Asynchronous reset in the middle of a partial group.
        step(1'b1, 6'h08, 1'b0, 1'b1, acc_flag);
        step(1'b1, 6'h08, 1'b0, 1'b1, acc_flag);
        in_valid = 1'b0;
        #1;
        check("pre_rst_in_ready", in_ready, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_acc  = n_acc - grp.size();
        grp.delete();
        m_done = 1'b0;
        step(1'b1, 6'h08, 1'b1, 1'b1, acc_flag);
        #1;
        check("post_rst_sum", out_data, 6'h08);
        check("post_rst_count", out_count, 1);
        step(1'b0, 6'h00, 1'b0, 1'b1, acc_flag);

        // Random stream, holding an unaccepted element stable until taken.
        pv       = 1'b0;
        pd       = '0;
        pl       = 1'b0;
        acc_flag = 1'b0;
        cyc      = 0;
        idx      = n_acc;
        while ((n_acc - idx) < 10000 && cyc < 60000) begin
            if (!(pv && !acc_flag)) begin
                pv = ($urandom % 4) != 0;
                pd = 6'($urandom);
                pl = ($urandom % 5) == 0;
            end
            step(pv, pd, pl, ($urandom % 3) != 0, acc_flag);
            cyc++;
        end
        check("rand_budget", ((n_acc - idx) >= 10000), 1);
        for (int i = 0; i < 8 && grp.size() > 0; i++) step(1'b1, 6'h08, 1'b1, 1'b1, acc_flag);
        for (int i = 0; i < 3; i++) step(1'b0, 6'h00, 1'b0, 1'b1, acc_flag);
        check("groups_out", n_out, n_closed);
        check("elems_total", out_sum, n_acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp6_group_accumulator.md
Name: fp6_group_accumulator

Overview:
Sequential reduction stage directly downstream of the FP6 multiplier array and wrapped around one fp6_adder. It consumes a stream of FP6 (E2M3: sign[5], exponent[4:3], mantissa[2:0]) partial products over a valid/ready handshake and folds each accepted value into a running FP6 sum. It emits one registered FP6 result per group. A group ends on in_last or after VEC_LEN elements.

Parameters:
VEC_LEN, 16, maximum elements per group; must be >= 1.
CNT_W, $clog2(VEC_LEN+1), width of the element counter and out_count.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  reset, asynchronous and active-low.
in_valid  input  1  in_data/in_last are valid.
in_ready  output  1  block can accept an element this cycle.
in_data  input  6  FP6 element to accumulate.
in_last  input  1  final element of the current group.
out_valid  output  1  group result is available.
out_ready  input  1  consumer accepts the result.
out_data  output  6  FP6 group sum.
out_count  output  CNT_W  number of elements folded into out_data (1..VEC_LEN).

Behaviour:
- Reset (rst_n=0, asynchronous, any state): state=IDLE; acc=6'b000000; count=0; out_valid=0; out_data=0; out_count=0; in_ready=0 while rst_n=0. Any partial group is discarded.
- State machine: IDLE, ACCUM, DONE.
  - IDLE: in_ready=1; acc=+0; count=0.
  - ACCUM: in_ready=1.
  - DONE: in_ready=0, out_valid=1.
- Accept: in_valid && in_ready.
  - On accept: acc <= fp6_adder(acc, in_data); count <= count+1.
  - IDLE->ACCUM on the first accept.
  - The first accept from IDLE yields acc = in_data exactly, because the adder returns the other operand when one is zero.
- Group end: an accept with in_last=1, or an accept with count==VEC_LEN-1.
  - Next cycle: state=DONE; out_data = adder result including that element; out_count = count+1; out_valid=1.
  - This applies from IDLE too (single-element group).
- Latency: out_valid rises exactly 1 cycle after the closing accept.
- DONE: out_data and out_count are held stable while out_valid && !out_ready; in_data is ignored.
  - On out_valid && out_ready: out_valid<=0, acc<=0, count<=0, state<=IDLE.
  - The next input is accepted no earlier than the cycle after the handshake. There is no same-cycle bypass; a 1-cycle bubble per group is accepted.
- Arithmetic: all addition goes through fp6_adder with no internal widening. Rounding, saturation and zero handling are exactly those of fp6_adder. Accumulation order is arrival order, left-associative: ((e0+e1)+e2)...
- Counter: count never exceeds VEC_LEN-1 in ACCUM. Hitting VEC_LEN without in_last closes the group. A following in_last-tagged element starts a new group.
- in_valid while in DONE: in_ready=0, so the element stays pending upstream and is not lost.
- out_data/out_count hold their last value after the handshake; they are don't-care when out_valid=0.

Decomposition:
- Shared package fp6_pkg:
  - typedef fp6_t (6-bit packed struct: sign, exp[1:0], man[2:0]).
  - constant FP6_ZERO=6'b000000.
  - constants FP6_EXP_W=2, FP6_MAN_W=3.
  - enum acc_state_t {IDLE, ACCUM, DONE}.
- Sub-module: the existing fp6_adder, instantiated once, combinational, between acc and in_data.
- No other sub-modules; the FSM, counter and output registers are local.

Test Plan:
- VEC_LEN=4; stream 0x08,0x08,0x00,0x00 (no in_last), out_ready=1 -> out_valid 1 cycle after 4th accept; out_data = golden fp6_adder fold (0x10 for a correct adder); out_count=4.
- Single element 0x2B with in_last=1 from IDLE -> out_data=0x2B, out_count=1, latency 1 cycle.
- 3 elements 0x08,0x28,0x00 with in_last on 3rd, out_ready held 0 for 5 cycles -> out_valid, out_data and out_count stable for 5 cycles; in_ready=0 throughout; no in_data consumed; IDLE the cycle after out_ready=1.
- Back-to-back groups with in_valid held 1 -> exactly one bubble cycle per group; second group's sum excludes the first group's values; acc restarts at +0.
- Assert rst_n=0 asynchronously mid-clock during ACCUM (count=2) -> out_valid=0, in_ready=0 immediately; after release, a fresh group of [0x08] returns 0x08 with out_count=1.
- Random 10k-element stream with random in_last, in_valid and out_ready against a golden model calling the fp6_adder reference function -> all out_data/out_count match; no element lost or duplicated.
